// File: rtl/noc_link_arbiter.sv
// noc_link_arbiter: round-robin arbiter with bounded burst hold, sharing one 16-bit NoC link among NUM_REQ flit sources
// ports: ACLK/ARESETn clock and sync active-low reset; req_data/req_valid/req_ready per-requester flit handshake;
//        net_data_out/net_valid_out/net_ready_in registered link output; grant_id last winner; fwd_cnt/drop_cnt statistics
module noc_link_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int GPU_ID = 9,
  parameter int BURST_MAX = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [NUM_REQ*16-1:0] req_data,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [15:0]           net_data_out,
  output logic                  net_valid_out,
  input  logic                  net_ready_in,
  output logic [IW-1:0]         grant_id,
  output logic [15:0]           fwd_cnt,
  output logic [7:0]            drop_cnt
);
  localparam logic [5:0] self_id = 6'(GPU_ID);
  localparam logic [7:0] burst_max = 8'(BURST_MAX);
  logic [IW-1:0] owner, sel, idx;
  logic [7:0] burst_cnt;
  logic out_free, keep, found, accept, drop;
  logic [15:0] flit;
  assign out_free = !net_valid_out || net_ready_in;
  // owner keeps the link only while its burst budget lasts; otherwise it is scanned last
  assign keep = burst_cnt != 8'd0 && req_valid[owner] && burst_cnt < burst_max;
  always_comb begin
    sel = owner;
    idx = owner;
    found = keep;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((int'(owner) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        sel = idx;
        found = 1'b1;
      end
    end
  end
  assign accept = ARESETn && out_free && req_valid[sel];
  always_comb begin
    req_ready = '0;
    req_ready[sel] = accept;
  end
  assign flit = req_data[{sel, 4'b0} +: 16];
  assign drop = flit[15:10] == self_id;
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      owner <= IW'(NUM_REQ - 1);
      burst_cnt <= '0;
      grant_id <= '0;
      net_data_out <= '0;
      net_valid_out <= 1'b0;
      fwd_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (accept) begin
        owner <= sel;
        burst_cnt <= keep ? burst_cnt + 8'd1 : 8'd1;
        grant_id <= sel;
        if (drop) begin
          if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end else begin
          net_data_out <= flit;
          net_valid_out <= 1'b1;
          fwd_cnt <= fwd_cnt + 16'd1;
        end
      end else if (!req_valid[owner]) begin
        burst_cnt <= '0;
      end
      if ((!accept || drop) && net_ready_in && net_valid_out) net_valid_out <= 1'b0;
    end
  end
endmodule

// File: tb/tb_noc_link_arbiter.sv
// tb_noc_link_arbiter: scoreboard bench driving a BURST_MAX=4 and a BURST_MAX=1 arbiter from shared stimulus
module tb_noc_link_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, net_ready;
  logic [3:0] req_valid;
  logic [15:0] fl [4];
  logic [63:0] req_data;
  assign req_data = {fl[3], fl[2], fl[1], fl[0]};
  logic [3:0] rr4, rr1;
  logic [15:0] d4, d1, fc4, fc1;
  logic v4, v1;
  logic [1:0] g4, g1;
  logic [7:0] dc4, dc1;
  noc_link_arbiter #(.NUM_REQ(4), .GPU_ID(9), .BURST_MAX(4)) u4 (
    .ACLK(clk), .ARESETn(rst_n), .req_data(req_data), .req_valid(req_valid), .req_ready(rr4),
    .net_data_out(d4), .net_valid_out(v4), .net_ready_in(net_ready), .grant_id(g4),
    .fwd_cnt(fc4), .drop_cnt(dc4));
  noc_link_arbiter #(.NUM_REQ(4), .GPU_ID(9), .BURST_MAX(1)) u1 (
    .ACLK(clk), .ARESETn(rst_n), .req_data(req_data), .req_valid(req_valid), .req_ready(rr1),
    .net_data_out(d1), .net_valid_out(v1), .net_ready_in(net_ready), .grant_id(g1),
    .fwd_cnt(fc1), .drop_cnt(dc1));
  int n_chk = 0;
  int n_err = 0;
  logic [17:0] q4 [$];
  logic [17:0] q1 [$];
  logic [17:0] e4, e1;
  int ord_f4 [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
  int ord_f1 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int ord_b4 [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
  int ord_b1 [12] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask
  task automatic push(input int ga, input int gb);
    q4.push_back({2'(ga), fl[ga]});
    q1.push_back({2'(gb), fl[gb]});
  endtask
  task automatic st(input string nm, input logic v, input logic [15:0] d, input logic [1:0] g,
                    input logic [15:0] fc, input logic [7:0] dc);
    chk({nm, "_valid4"}, 32'(v4), 32'(v));
    chk({nm, "_valid1"}, 32'(v1), 32'(v));
    chk({nm, "_data4"}, 32'(d4), 32'(d));
    chk({nm, "_data1"}, 32'(d1), 32'(d));
    chk({nm, "_grant4"}, 32'(g4), 32'(g));
    chk({nm, "_grant1"}, 32'(g1), 32'(g));
    chk({nm, "_fwd4"}, 32'(fc4), 32'(fc));
    chk({nm, "_fwd1"}, 32'(fc1), 32'(fc));
    chk({nm, "_drop4"}, 32'(dc4), 32'(dc));
    chk({nm, "_drop1"}, 32'(dc1), 32'(dc));
  endtask
  task automatic rdy(input string nm, input logic [3:0] exp);
    chk({nm, "_ready4"}, 32'(rr4), 32'(exp));
    chk({nm, "_ready1"}, 32'(rr1), 32'(exp));
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask
  always begin
    @(negedge clk);
    #2;
    if (rst_n && net_ready && v4) begin
      if (q4.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL u4_extra_flit: got %h grant %0d expected none", d4, g4);
      end else begin
        e4 = q4.pop_front();
        chk("u4_flit", 32'({g4, d4}), 32'(e4));
      end
    end
  end
  always begin
    @(negedge clk);
    #2;
    if (rst_n && net_ready && v1) begin
      if (q1.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL u1_extra_flit: got %h grant %0d expected none", d1, g1);
      end else begin
        e1 = q1.pop_front();
        chk("u1_flit", 32'({g1, d1}), 32'(e1));
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0;
    net_ready = 1'b1;
    req_valid = 4'b0101;
    fl[0] = 16'h2801;
    fl[1] = 16'h2C02;
    fl[2] = 16'h3003;
    fl[3] = 16'h3404;
    step(2);
    st("reset", 1'b0, 16'h0, 2'd0, 16'd0, 8'd0);
    rdy("reset", 4'b0000);
    req_valid = 4'b0000;
    rst_n = 1'b1;
    step(1);
    fl[2] = 16'h2C55;
    req_valid = 4'b0100;
    #1;
    rdy("single", 4'b0100);
    push(2, 2);
    step(1);
    req_valid = 4'b0000;
    st("single_out", 1'b1, 16'h2C55, 2'd2, 16'd1, 8'd0);
    step(1);
    chk("single_len4", 32'(v4), 32'd0);
    chk("single_len1", 32'(v1), 32'd0);
    step(1);
    do_reset();
    fl[2] = 16'h3003;
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) push(ord_f4[k], ord_f1[k]);
    step(8);
    req_valid = 4'b0000;
    chk("fair_fwd4", 32'(fc4), 32'd8);
    chk("fair_fwd1", 32'(fc1), 32'd8);
    step(2);
    do_reset();
    req_valid = 4'b0011;
    for (int k = 0; k < 12; k++) push(ord_b4[k], ord_b1[k]);
    step(12);
    req_valid = 4'b0000;
    chk("burst_fwd4", 32'(fc4), 32'd12);
    chk("burst_fwd1", 32'(fc1), 32'd12);
    step(2);
    do_reset();
    fl[0] = 16'h0C01;
    fl[1] = 16'h1002;
    req_valid = 4'b0001;
    push(0, 0);
    step(1);
    req_valid = 4'b0010;
    net_ready = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_data4", 32'(d4), 32'h0C01);
      chk("bp_data1", 32'(d1), 32'h0C01);
      chk("bp_valid4", 32'(v4), 32'd1);
      rdy("bp", 4'b0000);
      chk("bp_fwd4", 32'(fc4), 32'd1);
      chk("bp_fwd1", 32'(fc1), 32'd1);
      step(1);
    end
    net_ready = 1'b1;
    push(1, 1);
    #1;
    rdy("bp_release", 4'b0010);
    step(1);
    req_valid = 4'b0000;
    st("bp_next", 1'b1, 16'h1002, 2'd1, 16'd2, 8'd0);
    step(2);
    do_reset();
    fl[1] = 16'h2523;
    req_valid = 4'b0010;
    #1;
    rdy("drop", 4'b0010);
    step(1);
    st("drop_one", 1'b0, 16'h0, 2'd1, 16'd0, 8'd1);
    step(254);
    chk("drop_sat4", 32'(dc4), 32'hFF);
    chk("drop_sat1", 32'(dc1), 32'hFF);
    step(45);
    st("drop_300", 1'b0, 16'h0, 2'd1, 16'd0, 8'hFF);
    req_valid = 4'b0000;
    step(1);
    do_reset();
    fl[0] = 16'h2801;
    fl[1] = 16'h2C02;
    req_valid = 4'b0111;
    q4.push_back({2'd0, fl[0]});
    q1.push_back({2'd0, fl[0]});
    step(2);
    chk("mid_valid4", 32'(v4), 32'd1);
    rst_n = 1'b0;
    step(1);
    st("mid_reset", 1'b0, 16'h0, 2'd0, 16'd0, 8'd0);
    rdy("mid_reset", 4'b0000);
    rst_n = 1'b1;
    #1;
    rdy("mid_release", 4'b0001);
    push(0, 0);
    step(1);
    req_valid = 4'b0000;
    st("mid_first", 1'b1, 16'h2801, 2'd0, 16'd1, 8'd0);
    step(3);
    chk("sb_empty4", 32'(q4.size()), 32'd0);
    chk("sb_empty1", 32'(q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/noc_link_arbiter.md
# noc_link_arbiter

Round-robin arbiter that shares one GPU's 16-bit outbound network link among `NUM_REQ` local flit sources, such as the test-packet generator and the AXI bridging logic. Each flit is `{dest_gpu[5:0], payload[9:0]}`. A winning flit is registered onto `net_data_out`/`net_valid_out` with full throughput under backpressure. The arbiter supports bounded burst hold for a winner, discards self-addressed flits, and keeps forward and drop statistics.

## Interface
- `NUM_REQ`, 4, number of requesters; legal range 2..8.
- `GPU_ID`, 9, local GPU ID; flits whose `dest == GPU_ID[5:0]` are dropped.
- `BURST_MAX`, 4, maximum consecutive grants to one requester while others wait; legal range 1..255.
- `ACLK` in 1: the single clock; all logic is on the rising edge.
- `ARESETn` in 1: reset, synchronous and active-low.
- `req_data` in `NUM_REQ*16`: requester i drives flit `[16*i+15:16*i]`.
- `req_valid` in `NUM_REQ`: per-requester flit valid.
- `req_ready` out `NUM_REQ`: per-requester accept; combinational; at most one bit set.
- `net_data_out` out 16: registered flit to the NoC.
- `net_valid_out` out 1: registered flit valid.
- `net_ready_in` in 1: NoC accepts a flit when it and `net_valid_out` are both high.
- `grant_id` out `clog2(NUM_REQ)`: registered index of the last accepted requester.
- `fwd_cnt` out 16: flits forwarded; wraps 0xFFFF→0.
- `drop_cnt` out 8: self-addressed flits dropped; saturates at 0xFF.

## Operation
- `out_free = !net_valid_out || net_ready_in`.
- State is `owner` (index) and `burst_cnt` (8 bit). The burst logic has two states:
  - IDLE: `burst_cnt == 0`.
  - HOLD: `burst_cnt > 0`.
- Selection, combinational:
  - If HOLD, `req_valid[owner]` is high and `burst_cnt < BURST_MAX`, then `sel = owner`.
  - Otherwise `sel` is the first i with `req_valid[i]` set, scanning `owner+1, owner+2, …` modulo `NUM_REQ`. `owner` itself is scanned last.
- `req_ready[i] = out_free && (i == sel) && req_valid[sel]`.
- Accept is `req_valid[sel] && req_ready[sel]`. On accept:
  - If `sel == owner` and HOLD: `burst_cnt <= burst_cnt + 1`.
  - Otherwise: `owner <= sel`, `burst_cnt <= 1`.
  - `grant_id <= sel`.
- Flit load on accept:
  - Normal flit: `net_data_out <= flit`, `net_valid_out <= 1`, `fwd_cnt++`.
  - Dropped flit (`flit[15:10] == GPU_ID[5:0]`): output register is not loaded; `drop_cnt++` saturating. It still consumes the grant and burst slot.
- If there is no accept, or the accepted flit was dropped, and `net_ready_in && net_valid_out`: `net_valid_out <= 0`.
- If `req_valid[owner]` is low and no accept occurs: `burst_cnt <= 0`, returning to IDLE. `owner` is retained for rotation.
- When `burst_cnt == BURST_MAX` and another requester is valid, that requester wins.
- When `burst_cnt == BURST_MAX` and only `owner` is valid, the scan returns to `owner`, so `owner` wins again and `burst_cnt` restarts at 1.
- `net_data_out` holds its value while `net_valid_out && !net_ready_in`.
- Requesters must hold flit and valid stable until ready; the arbiter does not check this.

## Timing
- Reset, synchronous on an `ACLK` edge with `ARESETn` low:
  - `net_valid_out = 0`, `net_data_out = 0`, `grant_id = 0`.
  - `owner = NUM_REQ-1`, so requester 0 has first priority.
  - `burst_cnt = 0`, `fwd_cnt = 0`, `drop_cnt = 0`.
  - `req_ready` is forced to 0 while `ARESETn` is low.
- Reset mid-operation discards the in-flight output flit. No partial state survives.
- Latency: a flit accepted at edge N is on `net_data_out` with `net_valid_out = 1` after edge N.
- Throughput: one flit per cycle when `net_ready_in` stays high; no bubble on grant switch.
- Backpressure: with `net_valid_out = 1` and `net_ready_in = 0`, all `req_ready` bits are 0.
- Dropped flits are still accepted while `out_free` is low? No. Accept always requires `out_free`.
- Counters update on the same edge as the accept. `drop_cnt` stays at 0xFF once saturated.

## Test plan
- Single source: after reset, requester 2 sends 0x2C55 (dest 11) with `net_ready_in = 1`. Required: `req_ready = 0b0100` in the same cycle; `net_data_out = 0x2C55`, valid, for exactly one cycle; `grant_id = 2`; `fwd_cnt = 1`.
- Fairness: all 4 requesters valid continuously, `BURST_MAX = 1`, `net_ready_in = 1`. Required grant order 0, 1, 2, 3, 0, 1, …; `fwd_cnt = 8` after 8 cycles.
- Burst hold: `BURST_MAX = 4`, requesters 0 and 1 always valid. Required grants 0, 0, 0, 0, 1, 1, 1, 1, 0, …
- Backpressure: `net_ready_in = 0` for 5 cycles with flit 0x0C01 held. Required: `net_data_out` stable at 0x0C01, all `req_ready = 0`, `fwd_cnt` unchanged. On release, the next flit follows with no bubble.
- Self-drop: with `GPU_ID = 9`, requester 1 sends 0x2523 (dest 9). Required: accepted, `net_valid_out` stays 0, `drop_cnt = 1`, `fwd_cnt = 0`. 300 such flits leave `drop_cnt = 0xFF`.
- Reset mid-stream: assert `ARESETn = 0` while `net_valid_out = 1` and 3 requesters are valid. Required: next edge gives all outputs at reset values; the first grant after release goes to requester 0.
